// File: rtl/dev_unit.sv
// dev_unit: stallable load/store unit with base+/-offset addressing, valid/ack memory port and UART with RX FIFO
module dev_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int OFF_W    = 8,
    parameter int RX_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        req_en,
    output logic                        req_ready,
    input  logic                        req_wb,
    input  logic                        req_uart,
    input  logic                        req_neg,
    input  logic [OFF_W-1:0]            req_offset,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_val,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ack,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_data,
    output logic                        tx_valid,
    output logic [7:0]                  tx_data,
    input  logic                        tx_ready,
    output logic                        res_valid,
    output logic [DATA_W-1:0]           res_data,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic                        rx_overflow
);
    localparam int PW = $clog2(RX_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, MEM, RX, TX} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              we_q, we_d;
    logic              res_valid_q, res_valid_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        rx_mem_q [RX_DEPTH];
    logic              pop, push;

    // FIFO bookkeeping plus the request FSM; a pop frees a slot for a same-cycle push
    always_comb begin
        pop         = (state_q == RX) && (cnt_q != '0);
        push        = rx_valid && ((cnt_q != CW'(RX_DEPTH)) || pop);
        ovf_d       = ovf_q | (rx_valid & ~push);
        wptr_d      = wptr_q + PW'(push);
        rptr_d      = rptr_q + PW'(pop);
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        tx_data_d   = tx_data_q;
        res_data_d  = res_data_q;
        res_valid_d = 1'b0;
        case (state_q)
            IDLE: if (req_en) begin
                state_d   = req_uart ? (req_wb ? RX : TX) : MEM;
                addr_d    = req_neg ? req_addr - ADDR_W'(req_offset) : req_addr + ADDR_W'(req_offset);
                wdata_d   = req_val;
                we_d      = !req_uart && !req_wb;
                tx_data_d = req_val[7:0];
            end
            MEM: if (mem_ack) begin
                state_d     = IDLE;
                we_d        = 1'b0;
                res_valid_d = !we_q;
                res_data_d  = we_q ? res_data_q : mem_rdata;
            end
            RX: if (pop) begin
                state_d     = IDLE;
                res_valid_d = 1'b1;
                res_data_d  = DATA_W'(rx_mem_q[rptr_q]);
            end
            TX: if (tx_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            tx_data_q   <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            tx_data_q   <= tx_data_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            ovf_q       <= ovf_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (nreset && push) rx_mem_q[wptr_q] <= rx_data;
    end

    assign req_ready   = state_q == IDLE;
    assign mem_req     = state_q == MEM;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign tx_valid    = state_q == TX;
    assign tx_data     = tx_data_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign rx_count    = cnt_q;
    assign rx_overflow = ovf_q;
endmodule

// File: tb/tb_dev_unit.sv
// tb_dev_unit: randomized transaction-level check of dev_unit against a queue-based model
module tb_dev_unit;
    localparam int D = 8;

    logic        clk = 0, nreset = 0;
    logic        req_en = 0, req_ready, req_wb = 0, req_uart = 0, req_neg = 0;
    logic [7:0]  req_offset = 0;
    logic [31:0] req_addr = 0, req_val = 0;
    logic        mem_req, mem_we, mem_ack = 0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
    logic        rx_valid = 0, tx_valid, tx_ready = 0, res_valid, rx_overflow;
    logic [7:0]  rx_data = 0, tx_data;
    logic [31:0] res_data;
    logic [3:0]  rx_count;

    int total = 0, bad = 0;
    byte unsigned fq[$];
    bit ovf_m = 0, rnd_rx = 0;

    dev_unit #(.DATA_W(32), .ADDR_W(32), .OFF_W(8), .RX_DEPTH(D)) dut (
        .clk(clk), .nreset(nreset), .req_en(req_en), .req_ready(req_ready),
        .req_wb(req_wb), .req_uart(req_uart), .req_neg(req_neg), .req_offset(req_offset),
        .req_addr(req_addr), .req_val(req_val), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rx_valid(rx_valid), .rx_data(rx_data), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .res_valid(res_valid), .res_data(res_data),
        .rx_count(rx_count), .rx_overflow(rx_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock; the model sees the same rx push the DUT samples at this edge
    task automatic tick();
        if (rnd_rx) begin
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data  = 8'($urandom);
        end
        @(posedge clk);
        if (!nreset) begin
            fq.delete();
            ovf_m = 0;
        end else if (rx_valid) begin
            if (fq.size() < D) fq.push_back(rx_data);
            else ovf_m = 1;
        end
        #1;
        if (rnd_rx) rx_valid = 0;
    endtask

    task automatic fchk();
        chk("rx_count", rx_count, fq.size());
        chk("rx_overflow", rx_overflow, ovf_m);
    endtask

    task automatic accept(input bit wb, uart, neg, input logic [7:0] off, input logic [31:0] base, val);
        req_wb = wb; req_uart = uart; req_neg = neg; req_offset = off; req_addr = base; req_val = val;
        req_en = 1;
        tick();
        req_en = $urandom_range(0, 1);
        req_wb = $urandom_range(0, 1); req_uart = $urandom_range(0, 1); req_neg = $urandom_range(0, 1);
        req_offset = 8'($urandom); req_addr = $urandom; req_val = $urandom;
    endtask

    task automatic mem_op(input bit wb, neg, input logic [7:0] off, input logic [31:0] base, val,
                          input int waits, input logic [31:0] rdata);
        logic [31:0] ea;
        ea = neg ? base - {24'b0, off} : base + {24'b0, off};
        accept(wb, 0, neg, off, base, val);
        for (int i = 0; i <= waits; i++) begin
            chk("mem_req", mem_req, 1);
            chk("mem_addr", mem_addr, ea);
            chk("mem_we", mem_we, !wb);
            if (!wb) chk("mem_wdata", mem_wdata, val);
            chk("mem_busy", req_ready, 0);
            chk("mem_res_quiet", res_valid, 0);
            mem_rdata = $urandom;
            if (i == waits) begin
                mem_ack = 1;
                mem_rdata = rdata;
            end
            tick();
        end
        mem_ack = 0;
        req_en = 0;
        chk("mem_ready", req_ready, 1);
        chk("mem_res_valid", res_valid, wb);
        if (wb) chk("mem_res_data", res_data, rdata);
        chk("mem_req_drop", mem_req, 0);
        tick();
        chk("mem_res_pulse", res_valid, 0);
        fchk();
    endtask

    task automatic tx_op(input logic [31:0] val, input int stall);
        accept(0, 1, $urandom_range(0, 1), 8'($urandom), $urandom, val);
        for (int i = 0; i <= stall; i++) begin
            chk("tx_valid", tx_valid, 1);
            chk("tx_data", tx_data, val[7:0]);
            chk("tx_busy", req_ready, 0);
            chk("tx_no_mem", mem_req, 0);
            if (i == stall) tx_ready = 1;
            tick();
        end
        tx_ready = 0;
        req_en = 0;
        chk("tx_ready_done", req_ready, 1);
        chk("tx_valid_drop", tx_valid, 0);
        chk("tx_no_res", res_valid, 0);
        fchk();
    endtask

    // UART read: waits `delay` cycles and pushes pb when the FIFO is empty; pp pushes pb on the pop edge
    task automatic uart_read(input int delay, input bit pp, input logic [7:0] pb);
        byte unsigned exp;
        accept(1, 1, $urandom_range(0, 1), 8'($urandom), $urandom, $urandom);
        chk("rx_busy", req_ready, 0);
        if (fq.size() == 0) begin
            for (int i = 0; i < delay; i++) begin
                chk("rx_wait_busy", req_ready, 0);
                chk("rx_wait_quiet", res_valid, 0);
                tick();
            end
            rx_valid = 1; rx_data = pb;
            tick();
            rx_valid = 0;
            chk("rx_cnt_one", rx_count, 1);
            chk("rx_no_bypass", res_valid, 0);
        end
        exp = fq.pop_front();
        if (pp) begin rx_valid = 1; rx_data = pb; end
        tick();
        rx_valid = 0;
        req_en = 0;
        chk("rx_res_valid", res_valid, 1);
        chk("rx_res_data", res_data, {24'b0, exp});
        chk("rx_ready", req_ready, 1);
        fchk();
        tick();
        chk("rx_res_pulse", res_valid, 0);
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1; rx_data = 8'($urandom);
            tick();
        end
        rx_valid = 0;
    endtask

    initial begin
        #1;
        tick(); tick();
        chk("rst_ready", req_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_count", rx_count, 0);
        chk("rst_ovf", rx_overflow, 0);
        nreset = 1;
        tick();

        mem_op(1, 1, 8'h10, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        mem_op(0, 0, 8'h10, 32'hFFFFFFF8, 32'h1234, 1, 32'h0);
        mem_op(1, 0, 8'h00, 32'h40, 32'h0, 0, 32'hCAFEF00D);
        uart_read(5, 0, 8'h41);

        push_n(D);
        chk("full_count", rx_count, D);
        chk("full_no_ovf", rx_overflow, 0);
        uart_read(0, 1, 8'hA5);
        chk("full_pp_count", rx_count, D);
        chk("full_pp_no_ovf", rx_overflow, 0);

        nreset = 0; tick(); nreset = 1;
        fchk();
        push_n(D + 2);
        chk("ovf_count", rx_count, D);
        chk("ovf_flag", rx_overflow, 1);
        for (int i = 0; i < D; i++) uart_read(0, 0, 8'h00);
        chk("drain_count", rx_count, 0);
        chk("ovf_sticky", rx_overflow, 1);
        uart_read(2, 0, 8'h7E);

        accept(0, 1, 0, 8'h3, 32'h0, 32'h1357_9BDF);
        for (int i = 0; i < 4; i++) begin
            chk("stall_tx_valid", tx_valid, 1);
            chk("stall_tx_data", tx_data, 8'hDF);
            rx_valid = (i == 0); rx_data = 8'h99;
            tick();
        end
        rx_valid = 0;
        req_en = 0;
        chk("stall_fifo_nonempty", rx_count, 1);
        nreset = 0; tick(); nreset = 1;
        chk("abort_tx_valid", tx_valid, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_res", res_valid, 0);
        chk("abort_count", rx_count, 0);
        chk("abort_ovf", rx_overflow, 0);
        tick();

        for (int n = 0; n < 120; n++) begin
            int k;
            k = $urandom_range(0, 3);
            rnd_rx = (k != 3);
            if (k < 2) mem_op(k == 0, $urandom_range(0, 1), 8'($urandom), $urandom, $urandom,
                              $urandom_range(0, 4), $urandom);
            else if (k == 2) tx_op($urandom, $urandom_range(0, 3));
            else uart_read($urandom_range(0, 3), $urandom_range(0, 1), 8'($urandom));
            rnd_rx = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
